// File: rtl/ex_alu_if.sv
// ID/EX -> EX/MEM bundle for the ex_alu execute stage.
// The slave modport is the ALU side; the master modport is the pipeline side.
interface ex_alu_if;
  logic [2:0]  alu_sel_i;
  logic [7:0]  alu_op_i;
  logic [31:0] op_number_1_i;
  logic [31:0] op_number_2_i;
  logic        write_reg_en_i;
  logic [4:0]  write_reg_addr_i;
  logic        write_reg_en_o;
  logic [4:0]  write_reg_addr_o;
  logic [31:0] write_data_o;
  logic        stall_req_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  modport slave (
    input  alu_sel_i, alu_op_i, op_number_1_i, op_number_2_i,
           write_reg_en_i, write_reg_addr_i,
    output write_reg_en_o, write_reg_addr_o, write_data_o,
           stall_req_o, hi_o, lo_o
  );

  modport master (
    output alu_sel_i, alu_op_i, op_number_1_i, op_number_2_i,
           write_reg_en_i, write_reg_addr_i,
    input  write_reg_en_o, write_reg_addr_o, write_data_o,
           stall_req_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_alu.sv
// Execute-stage ALU with single-cycle multiply and HI/LO registers.
// Define EX_ALU_DIV_EN to include the 32-cycle restoring divider.
module ex_alu (
  input  logic     clk,
  input  logic     rst,
  ex_alu_if.slave  bus
);

  typedef enum logic [2:0] {
    SEL_NOP    = 3'b000,
    SEL_LOGIC  = 3'b001,
    SEL_SHIFT  = 3'b010,
    SEL_ARITH  = 3'b011,
    SEL_MULDIV = 3'b100
  } alu_sel_e;

  localparam logic [7:0] OP_AND   = 8'h01;
  localparam logic [7:0] OP_OR    = 8'h02;
  localparam logic [7:0] OP_XOR   = 8'h03;
  localparam logic [7:0] OP_NOR   = 8'h04;
  localparam logic [7:0] OP_SLL   = 8'h10;
  localparam logic [7:0] OP_SRL   = 8'h11;
  localparam logic [7:0] OP_SRA   = 8'h12;
  localparam logic [7:0] OP_ADD   = 8'h20;
  localparam logic [7:0] OP_SUB   = 8'h21;
  localparam logic [7:0] OP_SLT   = 8'h22;
  localparam logic [7:0] OP_SLTU  = 8'h23;
  localparam logic [7:0] OP_MULT  = 8'h30;
  localparam logic [7:0] OP_MULTU = 8'h31;
  localparam logic [7:0] OP_DIV   = 8'h32;
  localparam logic [7:0] OP_DIVU  = 8'h33;
  localparam logic [7:0] OP_MFHI  = 8'h34;
  localparam logic [7:0] OP_MFLO  = 8'h35;

  alu_sel_e    sel;
  logic [7:0]  op;
  logic [31:0] a, b;
  logic        is_mult, is_div;
  logic [31:0] result;
  logic [63:0] prod_s, prod_u;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        div_stall;

  assign sel     = alu_sel_e'(bus.alu_sel_i);
  assign op      = bus.alu_op_i;
  assign a       = bus.op_number_1_i;
  assign b       = bus.op_number_2_i;
  assign is_mult = (sel == SEL_MULDIV) && (op == OP_MULT || op == OP_MULTU);
  assign is_div  = (sel == SEL_MULDIV) && (op == OP_DIV  || op == OP_DIVU);

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    result = '0;
    case (sel)
      SEL_LOGIC: begin
        case (op)
          OP_AND:  result = a & b;
          OP_OR:   result = a | b;
          OP_XOR:  result = a ^ b;
          OP_NOR:  result = ~(a | b);
          default: result = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (op)
          OP_SLL:  result = b << a[4:0];
          OP_SRL:  result = b >> a[4:0];
          OP_SRA:  result = $unsigned($signed(b) >>> a[4:0]);
          default: result = '0;
        endcase
      end
      SEL_ARITH: begin
        case (op)
          OP_ADD:  result = a + b;
          OP_SUB:  result = a - b;
          OP_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
          OP_SLTU: result = {31'd0, (a < b)};
          default: result = '0;
        endcase
      end
      SEL_MULDIV: begin
        case (op)
          OP_MFHI: result = hi_q;
          OP_MFLO: result = lo_q;
          default: result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

`ifdef EX_ALU_DIV_EN
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // quo_q starts as the dividend and shifts quotient bits in from the right.
  logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic        quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
  logic        div_signed, div_retire;
  logic [31:0] a_abs, b_abs;
  logic [32:0] rem_shift, diff;

  assign div_signed = (op == OP_DIV);
  assign a_abs      = (div_signed && a[31]) ? -a : a;
  assign b_abs      = (div_signed && b[31]) ? -b : b;
  assign rem_shift  = {rem_q, quo_q[31]};
  assign diff       = rem_shift - {1'b0, dvs_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;
    div_stall  = 1'b0;
    div_retire = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (is_div) begin
          div_stall = 1'b1;
          if (b != 32'd0) begin
            quo_d     = a_abs;
            rem_d     = '0;
            dvs_d     = b_abs;
            quo_neg_d = div_signed && (a[31] ^ b[31]);
            rem_neg_d = div_signed && a[31];
            cnt_d     = '0;
            state_d   = DIV_BUSY;
          end else begin
            quo_d     = '1;
            rem_d     = a;
            quo_neg_d = 1'b0;
            rem_neg_d = 1'b0;
            state_d   = DIV_DONE;
          end
        end
      end
      DIV_BUSY: begin
        div_stall = 1'b1;
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_shift[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        div_retire = 1'b1;
        state_d    = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the divider datapath is not reset; it is always loaded in IDLE before it is read.
  always_ff @(posedge clk) begin
    quo_q     <= quo_d;
    rem_q     <= rem_d;
    dvs_q     <= dvs_d;
    quo_neg_q <= quo_neg_d;
    rem_neg_q <= rem_neg_d;
  end
`else
  assign div_stall = 1'b0;
`endif

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (is_mult) {hi_d, lo_d} = (op == OP_MULT) ? prod_s : prod_u;
`ifdef EX_ALU_DIV_EN
    if (div_retire) begin
      hi_d = rem_neg_q ? -rem_q : rem_q;
      lo_d = quo_neg_q ? -quo_q : quo_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign bus.stall_req_o      = div_stall && !rst;
  assign bus.write_reg_addr_o = bus.write_reg_addr_i;
  assign bus.write_reg_en_o   = bus.write_reg_en_i && !is_mult && !is_div &&
                                !bus.stall_req_o && !rst;
  assign bus.write_data_o     = rst ? 32'd0 : result;
  assign bus.hi_o             = hi_q;
  assign bus.lo_o             = lo_q;

endmodule

// File: tb/tb_ex_alu.sv
// Randomized scoreboard bench for ex_alu; the reference model follows the
// EX_ALU_DIV_EN setting of the build it is compiled with.
module tb_ex_alu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_alu_if bus ();
  ex_alu dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef EX_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          chk_hl;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_cyc  = 0;

  // Reference model state: architectural HI/LO plus a pending divide.
  logic [31:0] m_hi = '0, m_lo = '0, m_p_hi = '0, m_p_lo = '0;
  bit          m_hl_valid  = 1'b0;
  int          m_stall_left = 0;
  bit          m_done_pend  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [2:0] s, input logic [7:0] o,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    if (s == 3'd1) begin
      if (o == 8'h01) r = a & b;
      if (o == 8'h02) r = a | b;
      if (o == 8'h03) r = a ^ b;
      if (o == 8'h04) r = ~(a | b);
    end else if (s == 3'd2) begin
      if (o == 8'h10) r = b << a[4:0];
      if (o == 8'h11) r = b >> a[4:0];
      if (o == 8'h12) r = $unsigned($signed(b) >>> a[4:0]);
    end else if (s == 3'd3) begin
      if (o == 8'h20) r = a + b;
      if (o == 8'h21) r = a - b;
      if (o == 8'h22) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      if (o == 8'h23) r = (a < b) ? 32'd1 : 32'd0;
    end else if (s == 3'd4) begin
      if (o == 8'h34) r = m_hi;
      if (o == 8'h35) r = m_lo;
    end
    return r;
  endfunction

  // One clock of stimulus: drive, push the expected response, advance the model.
  task automatic cycle(input logic r, input logic [2:0] s, input logic [7:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic e, input logic [4:0] ad);
    exp_t   x;
    longint sa, sbv, q, rm, pr;
    logic [63:0] pu;
    bit     muldiv_blk;
    @(posedge clk);
    #1;
    rst                  = r;
    bus.alu_sel_i        = s;
    bus.alu_op_i         = o;
    bus.op_number_1_i    = a;
    bus.op_number_2_i    = b;
    bus.write_reg_en_i   = e;
    bus.write_reg_addr_i = ad;
    n_cyc++;
    x.tag    = $sformatf("cyc%0d sel%0d op%h", n_cyc, s, o);
    x.addr   = ad;
    x.hi     = m_hi;
    x.lo     = m_lo;
    x.chk_hl = m_hl_valid;
    x.stall  = 1'b0;
    x.we     = 1'b0;
    x.data   = '0;
    muldiv_blk = (s == 3'd4) && (o >= 8'h30) && (o <= 8'h33);
    if (r) begin
      m_hi = '0; m_lo = '0; m_hl_valid = 1'b1;
      m_stall_left = 0; m_done_pend = 1'b0;
    end else begin
      x.data = alu_ref(s, o, a, b);
      if (m_stall_left > 0) begin
        x.stall = 1'b1;
        m_stall_left--;
        if (m_stall_left == 0) m_done_pend = 1'b1;
      end else if (m_done_pend) begin
        m_hi = m_p_hi; m_lo = m_p_lo; m_done_pend = 1'b0;
      end else if (s == 3'd4 && o == 8'h30) begin
        sa = $signed(a); sbv = $signed(b); pr = sa * sbv;
        m_hi = pr[63:32]; m_lo = pr[31:0];
      end else if (s == 3'd4 && o == 8'h31) begin
        pu = {32'd0, a} * {32'd0, b};
        m_hi = pu[63:32]; m_lo = pu[31:0];
      end else if (DIV_EN && s == 3'd4 && (o == 8'h32 || o == 8'h33)) begin
        x.stall = 1'b1;
        if (b == 32'd0) begin
          m_p_hi = a; m_p_lo = 32'hFFFF_FFFF; m_done_pend = 1'b1;
        end else begin
          if (o == 8'h32) begin
            sa = $signed(a); sbv = $signed(b);
            q = sa / sbv; rm = sa % sbv;
            m_p_lo = q[31:0]; m_p_hi = rm[31:0];
          end else begin
            m_p_lo = a / b; m_p_hi = a % b;
          end
          m_stall_left = 32;
        end
      end
      x.we = e && !x.stall && !muldiv_blk;
    end
    sb.push_back(x);
  endtask

  // Issue one instruction and hold it (operands scrambled) while the model stalls.
  task automatic instr(input logic [2:0] s, input logic [7:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic e, input logic [4:0] ad);
    cycle(1'b0, s, o, a, b, e, ad);
    while (m_stall_left > 0 || m_done_pend)
      cycle(1'b0, s, o, $urandom, $urandom, 1'($urandom), ad);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 15));
      1:       return ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, " we"},    32'(bus.write_reg_en_o), 32'(e.we));
      check({e.tag, " addr"},  32'(bus.write_reg_addr_o), 32'(e.addr));
      check({e.tag, " data"},  bus.write_data_o, e.data);
      check({e.tag, " stall"}, 32'(bus.stall_req_o), 32'(e.stall));
      if (e.chk_hl) begin
        check({e.tag, " hi"}, bus.hi_o, e.hi);
        check({e.tag, " lo"}, bus.lo_o, e.lo);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] s;
    logic [7:0] o;
    rst                  = 1'b1;
    bus.alu_sel_i        = '0;
    bus.alu_op_i         = '0;
    bus.op_number_1_i    = '0;
    bus.op_number_2_i    = '0;
    bus.write_reg_en_i   = 1'b0;
    bus.write_reg_addr_i = '0;

    cycle(1'b1, 3'd3, 8'h20, 32'd5, 32'd6, 1'b1, 5'd3);
    cycle(1'b1, 3'd4, 8'h30, 32'd5, 32'd6, 1'b1, 5'd4);

    // Arithmetic and shift corners.
    instr(3'd3, 8'h20, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd1);
    instr(3'd3, 8'h22, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd2);
    instr(3'd3, 8'h23, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd3);
    instr(3'd2, 8'h12, 32'd4, 32'h8000_0000, 1'b1, 5'd4);
    instr(3'd0, 8'h00, 32'h1234, 32'h5678, 1'b1, 5'd5);
    instr(3'd1, 8'h07, 32'h1234, 32'h5678, 1'b1, 5'd6);

    // Multiply then immediate HI/LO reads.
    instr(3'd4, 8'h30, 32'hFFFF_FFFE, 32'd3, 1'b1, 5'd7);
    instr(3'd4, 8'h35, 32'd0, 32'd0, 1'b1, 5'd8);
    instr(3'd4, 8'h34, 32'd0, 32'd0, 1'b1, 5'd9);
    instr(3'd4, 8'h31, 32'hFFFF_FFFF, 32'd2, 1'b1, 5'd10);
    instr(3'd4, 8'h35, 32'd0, 32'd0, 1'b1, 5'd11);
    instr(3'd4, 8'h34, 32'd0, 32'd0, 1'b1, 5'd12);

    // Divides: signed, by zero, overflow corner, and the 10/3 case.
    instr(3'd4, 8'h32, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd13);
    instr(3'd4, 8'h35, 32'd0, 32'd0, 1'b1, 5'd14);
    instr(3'd4, 8'h34, 32'd0, 32'd0, 1'b1, 5'd15);
    instr(3'd4, 8'h33, 32'd5, 32'd0, 1'b1, 5'd16);
    instr(3'd4, 8'h34, 32'd0, 32'd0, 1'b1, 5'd17);
    instr(3'd4, 8'h35, 32'd0, 32'd0, 1'b1, 5'd18);
    instr(3'd4, 8'h32, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd19);
    instr(3'd4, 8'h35, 32'd0, 32'd0, 1'b1, 5'd20);
    instr(3'd4, 8'h32, 32'd10, 32'd3, 1'b1, 5'd21);
    instr(3'd4, 8'h34, 32'd0, 32'd0, 1'b1, 5'd22);

    // Reset in the middle of a divide, then a clean divide.
    instr(3'd4, 8'h31, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 5'd23);
    cycle(1'b0, 3'd4, 8'h32, 32'd100, 32'd7, 1'b1, 5'd24);
    repeat (5) cycle(1'b0, 3'd4, 8'h32, 32'd100, 32'd7, 1'b1, 5'd24);
    cycle(1'b1, 3'd4, 8'h32, 32'd100, 32'd7, 1'b1, 5'd24);
    cycle(1'b1, 3'd4, 8'h32, 32'd100, 32'd7, 1'b1, 5'd24);
    instr(3'd4, 8'h32, 32'd100, 32'd7, 1'b1, 5'd25);
    instr(3'd4, 8'h35, 32'd0, 32'd0, 1'b1, 5'd26);
    instr(3'd4, 8'h34, 32'd0, 32'd0, 1'b1, 5'd27);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      s = 3'($urandom_range(0, 7));
      case (s)
        3'd1:    o = 8'h01 + 8'($urandom_range(0, 3));
        3'd2:    o = 8'h10 + 8'($urandom_range(0, 2));
        3'd3:    o = 8'h20 + 8'($urandom_range(0, 3));
        3'd4:    o = 8'h30 + 8'($urandom_range(0, 5));
        default: o = 8'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) o = 8'($urandom);
      if ($urandom_range(0, 63) == 0)
        cycle(1'b1, s, o, $urandom, $urandom, 1'b1, 5'($urandom));
      else
        instr(s, o, rnd_operand(), rnd_operand(), 1'($urandom), 5'($urandom));
    end

    @(posedge clk);
    repeat (2) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d responses left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
